step_sequencer: RTL

Parametrised, sensor-gated motion sequencer for the process controller. It is the successor to the fixed three-stage start/sensor state machine. It runs a configurable number of steps. Each step drives a one-cycle motor advance pulse, then waits for that step's sensor. The block adds per-step enable masking, a wait timeout with a fault state, abort, and done/step status. It sits between the operator/start logic and the motor and actuator drivers.

---
 rtl/step_seq_pkg.sv | 39 +++
 rtl/step_sequencer_timer.sv | 27 ++
 rtl/step_sequencer.sv | 125 ++++++++++++
 3 files changed

// File: rtl/step_seq_pkg.sv
// Shared types, motor command codes and the next-enabled-step search
// used by the step sequencer.
package step_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PULSE,
    WAIT,
    FINISH,
    FAULT
  } state_t;

  localparam logic [1:0] M_STOP = 2'b00;
  localparam logic [1:0] M_ADV  = 2'b01;
  localparam logic [1:0] M_FIN  = 2'b10;

  localparam int MAX_STEPS = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // Lowest enabled step at or above 'from', limited to the first n_steps bits.
  function automatic pick_t next_enabled(input logic [MAX_STEPS-1:0] mask,
                                         input logic [4:0]           from,
                                         input int                   n_steps);
    pick_t r;
    r = '0;
    for (int i = MAX_STEPS - 1; i >= 0; i--) begin
      if (i < n_steps && mask[i] && (5'(i) >= from)) begin
        r.found = 1'b1;
        r.idx   = 4'(i);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/step_sequencer_timer.sv
// Per-step WAIT timeout counter; expired flags the last permitted WAIT cycle.
module seq_timer #(
  parameter int TO_W    = 8,
  parameter int TIMEOUT = 200
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [TO_W-1:0] count_q;

  assign expired = (count_q == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (en && !expired) begin
      count_q <= count_q + 1'b1;
    end
  end

endmodule

// File: rtl/step_sequencer.sv
// Sensor-gated motion sequencer: per step a one-cycle advance pulse, then a
// bounded wait for that step's sensor, with skip mask, abort and fault.
module step_sequencer
  import step_seq_pkg::*;
#(
  parameter int N_STEPS = 4,
  parameter int TIMEOUT = 200,
  parameter int TO_W    = 8,
  localparam int IDX_W  = (N_STEPS > 1) ? $clog2(N_STEPS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [N_STEPS-1:0] step_en,
  input  logic [N_STEPS-1:0] sensor,
  output logic [1:0]         M,
  output logic               G,
  output logic               done,
  output logic               fault,
  output logic [IDX_W-1:0]   step
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [N_STEPS-1:0] en_q, en_d;
  logic [1:0]         m_q;
  logic               g_q, done_q, fault_q;
  logic [IDX_W-1:0]   step_q;
  logic               hit, expired;
  pick_t              first_pick, next_pick;

  assign hit        = (state_q == WAIT) && sensor[idx_q];
  assign first_pick = next_enabled(MAX_STEPS'(step_en), 5'd0, N_STEPS);
  assign next_pick  = next_enabled(MAX_STEPS'(en_q), 5'(idx_q) + 5'd1, N_STEPS);

  // Counter is held clear outside WAIT, so every WAIT entry starts from zero.
  seq_timer #(
    .TO_W   (TO_W),
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (state_q != WAIT),
    .en     ((state_q == WAIT) && !hit),
    .expired(expired)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    en_d    = en_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          en_d = step_en;
          if (first_pick.found) begin
            state_d = PULSE;
            idx_d   = IDX_W'(first_pick.idx);
          end else begin
            state_d = FINISH;
          end
        end
      end
      PULSE: state_d = WAIT;
      WAIT: begin
        // A sensor arriving on the expiry cycle still counts as success.
        if (hit) begin
          if (next_pick.found) begin
            state_d = PULSE;
            idx_d   = IDX_W'(next_pick.idx);
          end else begin
            state_d = FINISH;
          end
        end else if (expired) begin
          state_d = FAULT;
        end
      end
      FINISH: begin
        state_d = IDLE;
        idx_d   = '0;
      end
      FAULT: state_d = FAULT;
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
    if (abort) begin
      state_d = IDLE;
      idx_d   = '0;
    end
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      en_q    <= '0;
      m_q     <= M_STOP;
      g_q     <= 1'b0;
      done_q  <= 1'b0;
      fault_q <= 1'b0;
      step_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      en_q    <= en_d;
      m_q     <= (state_d == PULSE)  ? M_ADV :
                 (state_d == FINISH) ? M_FIN : M_STOP;
      g_q     <= (state_d == PULSE) || (state_d == WAIT) || (state_d == FINISH);
      done_q  <= (state_d == FINISH);
      fault_q <= (state_d == FAULT);
      step_q  <= (state_d == IDLE) ? '0 : idx_d;
    end
  end

  assign M     = m_q;
  assign G     = g_q;
  assign done  = done_q;
  assign fault = fault_q;
  assign step  = step_q;

endmodule
